serial_mod_engine: RTL and testbench
====================================

# serial_mod_engine

Bit-serial modulo unit that computes `data_in mod modulus` over a WIDTH-bit operand. The operand is processed MSB-first, one bit per clock, using the recurrence r ← (2r + bit) mod m. It generalises the team's fixed 8-bit / mod-5 shift-register datapath in three ways: parameterised operand width, a run-time programmable modulus, and a start/busy/done handshake with an error flag. It sits between a register-file write port and the status readout, and one instance serves any modulus up to 2^MOD_W−1.

## Interface
Parameters:
- WIDTH, default 8: operand width in bits, ≥2.
- MOD_W, default 4: modulus and result width in bits, ≥2.
- CNT_W, default $clog2(WIDTH+1): bit-counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- start  in  1  request; sampled only in IDLE.
- data_in  in  WIDTH  operand; captured on the accepting edge.
- modulus  in  MOD_W  modulus m; captured on the accepting edge.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; high only in DONE.
- result  out  MOD_W  final residue; held until the next completion.
- err  out  1  high when the captured m==0; held alongside result.
- bit_cnt  out  CNT_W  bits consumed so far (debug).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - operand register ← data_in; m_reg ← modulus.
  - residue ← 0; bit_cnt ← 0; next state SHIFT.
- SHIFT, each edge:
  - t = {residue, op[WIDTH-1]} (MOD_W+1 bits).
  - residue ← (t ≥ m_reg) ? t − m_reg : t. A single conditional subtract is sufficient because residue < m_reg.
  - Operand shifts left and zero-fills; bit_cnt increments.
  - When bit_cnt==WIDTH−1 at the edge, next state is DONE.
  - On that same edge, result ← the final residue and err ← (m_reg==0).
- DONE: lasts one cycle, with done=1. Next state is IDLE unconditionally.
- m_reg==0: the datapath runs with its normal latency. At completion, result=0 and err=1.
- m_reg==1: result=0, err=0. This falls out naturally from the recurrence.
- start while busy (SHIFT or DONE) is ignored. It is neither queued nor captured.
- start held high continuously: a new operation is accepted on each IDLE cycle, giving a back-to-back period of WIDTH+2 cycles.
- Changes to data_in or modulus after the accepting edge have no effect on the operation in progress.

## Timing
- Reset values: state=IDLE; busy=0, done=0, result=0, err=0, bit_cnt=0; operand, residue and m_reg all 0.
- reset asserted mid-operation: the block returns to IDLE immediately and asynchronously. The partial result is discarded and result/err are cleared. No done pulse is produced.
- Accepting edge E0 puts the block in SHIFT, so busy=1 from E0.
- Edges E1…EWIDTH each consume one bit.
- result/err update at edge EWIDTH. done is high in the cycle after EWIDTH.
- Edge EWIDTH+1 returns the block to IDLE; busy=0 and done=0.
- Latency from the accepting edge to the done pulse is WIDTH cycles.
- result is valid together with done and remains stable until the next EWIDTH.

## Structure
- Package serial_mod_pkg holds:
  - the state_t enum {IDLE, SHIFT, DONE}, 2 bits;
  - the localparam for the state encoding.
- Sub-module serial_residue (param MOD_W):
  - Ports: clk, reset, clr, en, bit_in, m.
  - Output: residue.
  - Contents: the residue register and the conditional subtractor.
- Top level contains the FSM, the operand shift register, bit_cnt, and the result/err registers.

## Test plan
- WIDTH=8, MOD_W=4: data_in=0xC8, modulus=5, start pulse → done 8 cycles after acceptance, result=0, err=0.
- WIDTH=8: data_in=0xFF, modulus=7 → result=3. Immediately follow with data_in=0x00, modulus=7 → result=0, and confirm result=3 is held until the second completion.
- WIDTH=16, MOD_W=4: data_in=0xFFFF, modulus=13 → result=2, done 16 cycles after acceptance.
- modulus=0, data_in=0x5A → err=1, result=0, latency unchanged. Then modulus=1 → result=0, err=0.
- start pulsed again during SHIFT with a different data_in → ignored; the original result is produced and exactly one done pulse occurs.
- reset asserted at bit 4 of an operation → busy, done, result and bit_cnt read 0 immediately. After release, a new start with 0xC8 mod 5 gives result=0.

Source files
------------

// File: rtl/serial_mod_pkg.sv
// Shared types for the bit-serial modulo engine.
package serial_mod_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_residue.sv
// Residue register with a single conditional subtract per consumed bit:
// r <= (2r + bit) mod m, valid because r < m on entry.
module serial_residue #(
    parameter int MOD_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    input  logic [MOD_W-1:0] m,
    output logic [MOD_W-1:0] residue
);
    logic [MOD_W:0]   t;
    logic [MOD_W:0]   diff;
    logic [MOD_W-1:0] residue_d;

    always_comb begin
        t         = {residue, bit_in};
        diff      = t - {1'b0, m};
        residue_d = residue;
        if (clr) begin
            residue_d = '0;
        end else if (en) begin
            residue_d = (t >= {1'b0, m}) ? diff[MOD_W-1:0] : t[MOD_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            residue <= '0;
        end else begin
            residue <= residue_d;
        end
    end

endmodule

// File: rtl/serial_mod_engine.sv
// Bit-serial data_in mod modulus, MSB first, one bit per clock, with a
// start/busy/done handshake and an err flag for a zero modulus.
module serial_mod_engine
    import serial_mod_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MOD_W = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [MOD_W-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [MOD_W-1:0] result,
    output logic             err,
    output logic [CNT_W-1:0] bit_cnt
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q;
    logic [MOD_W-1:0] m_q;
    logic [MOD_W-1:0] result_q;
    logic [MOD_W-1:0] residue;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             accept;
    logic             shift_en;
    logic             last_bit;

    assign accept   = (state_q == IDLE) && start;
    assign shift_en = (state_q == SHIFT);
    assign last_bit = shift_en && (cnt_q == CNT_W'(WIDTH - 1));
    assign bit_cnt  = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In DONE the residue register already holds the final value, so the
    // outputs present it directly; result_q/err_q latch it on leaving DONE.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        result = result_q;
        err    = err_q;
        if (state_q == DONE) begin
            result = (m_q == '0) ? '0 : residue;
            err    = (m_q == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= data_in;
                m_q   <= modulus;
                cnt_q <= '0;
            end else if (shift_en) begin
                op_q  <= {op_q[WIDTH-2:0], 1'b0};
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == DONE) begin
                result_q <= result;
                err_q    <= err;
            end
        end
    end

    serial_residue #(
        .MOD_W(MOD_W)
    ) u_residue (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (shift_en),
        .bit_in (op_q[WIDTH-1]),
        .m      (m_q),
        .residue(residue)
    );

endmodule

// File: tb/tb_serial_mod_engine.sv
// Bench for serial_mod_engine: vector table, multi-cycle corner sequences and
// randomized operands against a plain-arithmetic modulo model.
module tb_serial_mod_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        s8, s16;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [3:0]  m8, m16;
    logic        busy8, done8, err8, busy16, done16, err16;
    logic [3:0]  r8, r16;
    logic [3:0]  c8;
    logic [4:0]  c16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_mod_engine #(.WIDTH(8), .MOD_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .data_in(d8), .modulus(m8),
        .busy(busy8), .done(done8), .result(r8), .err(err8), .bit_cnt(c8)
    );

    serial_mod_engine #(.WIDTH(16), .MOD_W(4)) dut16 (
        .clk(clk), .reset(reset), .start(s16), .data_in(d16), .modulus(m16),
        .busy(busy16), .done(done16), .result(r16), .err(err16), .bit_cnt(c16)
    );

    typedef struct {
        logic [7:0] d;
        logic [3:0] m;
        logic [3:0] r;
        logic       e;
        bit         hc;
        logic [3:0] hv;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [3:0] ref_mod(input int unsigned d, input int unsigned m);
        if (m == 0) return 4'd0;
        return 4'(d % m);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run8(input logic [7:0] d, input logic [3:0] m, input bit hold_chk,
                        input logic [3:0] hold_val, output logic [3:0] res,
                        output logic e, output int lat, output logic [3:0] cnt);
        @(negedge clk);
        s8 = 1'b1; d8 = d; m8 = m;
        @(negedge clk);
        s8 = 1'b0; d8 = ~d; m8 = m + 4'd1;
        check("busy_after_accept", 32'(busy8), 32'd1);
        lat = 0;
        while (!done8 && lat < 40) begin
            if (hold_chk && lat == 4) check("result_hold", 32'(r8), 32'(hold_val));
            @(negedge clk);
            lat++;
        end
        res = r8; e = err8; cnt = c8;
        @(negedge clk);
        check("busy_back_idle", 32'(busy8), 32'd0);
        check("done_one_cycle", 32'(done8), 32'd0);
    endtask

    task automatic run16(input logic [15:0] d, input logic [3:0] m,
                         output logic [3:0] res, output logic e, output int lat,
                         output logic [4:0] cnt);
        @(negedge clk);
        s16 = 1'b1; d16 = d; m16 = m;
        @(negedge clk);
        s16 = 1'b0; d16 = ~d;
        lat = 0;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        res = r16; e = err16; cnt = c16;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] res;
        logic [4:0] cnt16;
        logic [3:0] cnt;
        logic [3:0] got;
        logic       e;
        int         lat, pulses, first, second;

        tbl[0] = '{8'hC8, 4'd5,  4'd0, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{8'hFF, 4'd7,  4'd3, 1'b0, 1'b0, 4'd0};
        tbl[2] = '{8'h00, 4'd7,  4'd0, 1'b0, 1'b1, 4'd3};
        tbl[3] = '{8'h5A, 4'd0,  4'd0, 1'b1, 1'b0, 4'd0};
        tbl[4] = '{8'h5A, 4'd1,  4'd0, 1'b0, 1'b0, 4'd0};
        tbl[5] = '{8'h80, 4'd3,  4'd2, 1'b0, 1'b0, 4'd0};
        tbl[6] = '{8'h7B, 4'd11, 4'd2, 1'b0, 1'b0, 4'd0};
        tbl[7] = '{8'hE9, 4'd9,  4'd8, 1'b0, 1'b0, 4'd0};
        tbl[8] = '{8'hFF, 4'd15, 4'd0, 1'b0, 1'b1, 4'd8};
        tbl[9] = '{8'h01, 4'd2,  4'd1, 1'b0, 1'b0, 4'd0};

        reset = 1'b1; s8 = 1'b0; s16 = 1'b0;
        d8 = '0; d16 = '0; m8 = '0; m16 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_result", 32'(r8), 32'd0);
        check("rst_err", 32'(err8), 32'd0);
        check("rst_bit_cnt", 32'(c8), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run8(tbl[i].d, tbl[i].m, tbl[i].hc, tbl[i].hv, res, e, lat, cnt);
            check($sformatf("tbl%0d_result", i), 32'(res), 32'(tbl[i].r));
            check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("tbl%0d_bit_cnt", i), 32'(cnt), 32'd8);
        end

        // Mid-operation reset: previous result (1) must be visible until then.
        @(negedge clk);
        s8 = 1'b1; d8 = 8'hE9; m8 = 4'd9;
        @(negedge clk);
        s8 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_bit_cnt", 32'(c8), 32'd4);
        check("pre_reset_hold", 32'(r8), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy8), 32'd0);
        check("async_rst_done", 32'(done8), 32'd0);
        check("async_rst_result", 32'(r8), 32'd0);
        check("async_rst_bit_cnt", 32'(c8), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("no_done_after_reset", 32'(pulses), 32'd0);
        run8(8'hC8, 4'd5, 1'b0, 4'd0, res, e, lat, cnt);
        check("post_reset_result", 32'(res), 32'd0);
        check("post_reset_latency", 32'(lat), 32'd8);

        // Start pulsed during SHIFT with a different operand is ignored.
        @(negedge clk);
        s8 = 1'b1; d8 = 8'h7B; m8 = 4'd11;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        s8 = 1'b1; d8 = 8'hFF; m8 = 4'd7;
        @(negedge clk);
        s8 = 1'b0;
        pulses = 0; got = 4'hF;
        for (int n = 0; n < 20; n++) begin
            if (done8) begin
                pulses++;
                got = r8;
            end
            @(negedge clk);
        end
        check("busy_start_pulses", 32'(pulses), 32'd1);
        check("busy_start_result", 32'(got), 32'd2);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        s8 = 1'b1; d8 = 8'hC8; m8 = 4'd5;
        first = -1; second = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done8) begin
                check("b2b_result", 32'(r8), 32'd0);
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        s8 = 1'b0;
        check("b2b_period", 32'(second - first), 32'd10);
        repeat (12) @(negedge clk);

        run16(16'hFFFF, 4'd13, res, e, lat, cnt16);
        check("w16_result", 32'(res), 32'd2);
        check("w16_err", 32'(e), 32'd0);
        check("w16_latency", 32'(lat), 32'd16);
        check("w16_bit_cnt", 32'(cnt16), 32'd16);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] dr;
            logic [3:0]  mr;
            dr = 16'($urandom);
            mr = 4'($urandom_range(0, 15));
            run16(dr, mr, res, e, lat, cnt16);
            check("w16_rand_result", 32'(res), 32'(ref_mod(32'(dr), 32'(mr))));
            check("w16_rand_err", 32'(e), 32'(mr == 4'd0));
            check("w16_rand_latency", 32'(lat), 32'd16);
        end

        for (int i = 0; i < 150; i++) begin
            logic [7:0] dr;
            logic [3:0] mr;
            dr = 8'($urandom);
            mr = 4'($urandom_range(0, 15));
            run8(dr, mr, 1'b0, 4'd0, res, e, lat, cnt);
            check("w8_rand_result", 32'(res), 32'(ref_mod(32'(dr), 32'(mr))));
            check("w8_rand_err", 32'(e), 32'(mr == 4'd0));
            check("w8_rand_latency", 32'(lat), 32'd8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
